v_upd_sched: RTL and testbench
==============================

// Module: v_upd_sched
//
// PURPOSE
// - Buffers incoming list-update commands and issues them into the 4-stage update pipeline.
// - Owns the single state-table read port, shared between the query pipe (S0 lookup) and update issue.
// - Query has strict priority on the read port; the query path is latency-constrained and never stalls.
// - An update is held back while any in-flight update (S1..S4) targets the same prod_id.
//
// PARAMETERS
// - FIFO_N   4  command buffer depth (power of 2, >=2)
// - STARVE_N 8  consecutive blocked cycles before o_starve asserts (>=1)
//
// PORTS
// - clk             in   1      clock
// - rst             in   1      reset, asynchronous, active-high
// - i_cmd_vld       in   1      update command valid
// - i_cmd           in   upd_cmd_t  {op, prod_id, key, volume}
// - o_cmd_rdy       out  1      command accepted when i_cmd_vld & o_cmd_rdy
// - i_lut_vld       in   1      query lookup this cycle
// - i_lut_prod_id   in   id_t   query prod_id
// - o_state_ren     out  1      state-table read enable
// - o_state_raddr   out  addr_t state-table read address
// - o_upd_vld       out  1      update issued into pipeline S0
// - o_upd_cmd       out  upd_cmd_t  issued command
// - i_sN_upd_vld_r  in   1      N=1..4, in-flight valid per stage
// - i_sN_upd_prod_id_r in id_t  N=1..4, in-flight prod_id per stage
// - o_busy          out  1      buffer non-empty
// - o_starve        out  1      head blocked >= STARVE_N consecutive cycles
// - o_perf_*        out  32     perf counters (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset: FIFO emptied, starve count 0, o_cmd_rdy=0, o_busy=0, o_starve=0, perf counters 0.
// - Reset mid-operation: all buffered commands are discarded; no in-flight state is held locally.
// - o_cmd_rdy is a flop: 1 from the first cycle after reset while occupancy < FIFO_N.
//   - Computed from next occupancy.
//   - When the FIFO is full, a same-cycle pop does not let a push in; rdy rises the next cycle.
// - Push and pop in the same cycle: occupancy unchanged; pointers wrap mod FIFO_N.
// - No bypass: a command pushed in cycle N issues in cycle N+1 at the earliest.
// - haz = OR over N=1..4 of (i_sN_upd_vld_r & i_sN_upd_prod_id_r == head.prod_id).
// - issue = busy & !i_lut_vld & !haz. Purely combinational.
//   - o_upd_vld = issue; o_upd_cmd = head.
//   - FIFO pops on issue.
// - Read port, combinational:
//   - o_state_ren = i_lut_vld | issue.
//   - o_state_raddr = i_lut_vld ? i_lut_prod_id : head.prod_id.
// - Back-to-back same-id commands serialise: the second issues once the first leaves S4.
//   - Earliest issue is 5 cycles after the first.
// - Starve counter:
//   - Increments (saturating at STARVE_N) each cycle with busy & !issue.
//   - Clears on issue or when empty.
//   - o_starve = (cnt == STARVE_N), registered.
// - In-order issue only; a hazarded head blocks younger commands (head-of-line).
//
// CONFIGURATION
// - V_UPD_SCHED_PERF_EN defined: three 32-bit wrapping counters.
//   - o_perf_issue_cnt: increments on issue.
//   - o_perf_lut_stall_cnt: busy & i_lut_vld.
//   - o_perf_haz_stall_cnt: busy & !i_lut_vld & haz.
// - V_UPD_SCHED_PERF_EN undefined: perf ports tied to '0; no counter flops.
//
// STRUCTURE
// - Additions to v_pkg:
//   - upd_op_t
//   - upd_cmd_t struct {op, prod_id, key, volume}
//   - UPD_SCHED_FIFO_N and UPD_SCHED_STARVE_N defaults
// - Sub-module v_upd_sched_fifo: FIFO_N x upd_cmd_t, rd/wr pointers, occupancy, registered full/empty.
// - Top level holds the hazard compare, read-port mux, starve counter and perf counters.
//
// TESTING
// - Reset, then push A(id=3) with no lut and no in-flight -> o_upd_vld=1 next cycle, raddr=3, o_busy=0 after.
// - i_lut_vld=1 (id=7) held 3 cycles with A buffered -> raddr=7, no issue; A issues in the cycle lut drops.
// - Push A(id=5), B(id=5) -> A issues at t; B held at t+1..t+4 (S1..S4 hit); B issues at t+5.
// - Push 4 commands with lut held high -> o_cmd_rdy=0; push attempt dropped; rdy=1 the cycle after the first pop.
// - Hazard held 8 cycles, STARVE_N=8 -> o_starve=1 after 8 blocked cycles; clears the cycle after issue.
// - rst asserted mid-stream with 3 buffered -> outputs reset immediately; no issue after release until a new push.

Source files
------------

// File: rtl/v_upd_sched_pkg.sv
// Shared types for the list-update scheduler: command struct, opcode enum, id/address types
// and default FIFO / starvation depths.
package v_upd_sched_pkg;

  localparam int ID_W  = 8;
  localparam int KEY_W = 16;
  localparam int VOL_W = 32;

  localparam int UPD_SCHED_FIFO_N   = 4;
  localparam int UPD_SCHED_STARVE_N = 8;

  typedef logic [ID_W-1:0]         id_t;
  // The state table is indexed directly by prod_id.
  typedef id_t                     addr_t;
  typedef logic [KEY_W-1:0]        key_t;
  typedef logic signed [VOL_W-1:0] vol_t;

  typedef enum logic [1:0] {
    UPD_ADD = 2'd0,
    UPD_DEL = 2'd1,
    UPD_MOD = 2'd2,
    UPD_CLR = 2'd3
  } upd_op_t;

  typedef struct packed {
    upd_op_t op;
    id_t     prod_id;
    key_t    key;
    vol_t    volume;
  } upd_cmd_t;

endpackage

// File: rtl/v_upd_sched_if.sv
// Signal bundle between the update scheduler and its surroundings; master is the scheduler,
// slave is the environment.
interface v_upd_sched_if;
  import v_upd_sched_pkg::*;

  logic        i_cmd_vld;
  upd_cmd_t    i_cmd;
  logic        o_cmd_rdy;

  logic        i_lut_vld;
  id_t         i_lut_prod_id;

  logic        o_state_ren;
  addr_t       o_state_raddr;

  logic        o_upd_vld;
  upd_cmd_t    o_upd_cmd;

  logic        i_s1_upd_vld_r;
  id_t         i_s1_upd_prod_id_r;
  logic        i_s2_upd_vld_r;
  id_t         i_s2_upd_prod_id_r;
  logic        i_s3_upd_vld_r;
  id_t         i_s3_upd_prod_id_r;
  logic        i_s4_upd_vld_r;
  id_t         i_s4_upd_prod_id_r;

  logic        o_busy;
  logic        o_starve;
  logic [31:0] o_perf_issue_cnt;
  logic [31:0] o_perf_lut_stall_cnt;
  logic [31:0] o_perf_haz_stall_cnt;

  modport master (
    input  i_cmd_vld, i_cmd, i_lut_vld, i_lut_prod_id,
    input  i_s1_upd_vld_r, i_s1_upd_prod_id_r, i_s2_upd_vld_r, i_s2_upd_prod_id_r,
    input  i_s3_upd_vld_r, i_s3_upd_prod_id_r, i_s4_upd_vld_r, i_s4_upd_prod_id_r,
    output o_cmd_rdy, o_state_ren, o_state_raddr, o_upd_vld, o_upd_cmd,
    output o_busy, o_starve, o_perf_issue_cnt, o_perf_lut_stall_cnt, o_perf_haz_stall_cnt
  );

  modport slave (
    output i_cmd_vld, i_cmd, i_lut_vld, i_lut_prod_id,
    output i_s1_upd_vld_r, i_s1_upd_prod_id_r, i_s2_upd_vld_r, i_s2_upd_prod_id_r,
    output i_s3_upd_vld_r, i_s3_upd_prod_id_r, i_s4_upd_vld_r, i_s4_upd_prod_id_r,
    input  o_cmd_rdy, o_state_ren, o_state_raddr, o_upd_vld, o_upd_cmd,
    input  o_busy, o_starve, o_perf_issue_cnt, o_perf_lut_stall_cnt, o_perf_haz_stall_cnt
  );

endinterface

// File: rtl/v_upd_sched_fifo.sv
// Command buffer for the update scheduler: FIFO_N entries, head visible combinationally,
// registered ready/empty/full derived from next occupancy.
module v_upd_sched_fifo
  import v_upd_sched_pkg::*;
#(
  parameter int FIFO_N = UPD_SCHED_FIFO_N
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_vld,
  input  logic     pop,
  input  upd_cmd_t din,
  output upd_cmd_t head,
  output logic     rdy,
  output logic     empty
);

  localparam int PTR_W = $clog2(FIFO_N);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_N);

  upd_cmd_t         mem [FIFO_N];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             full;
  logic             do_push, do_pop;

  assign do_push = wr_vld & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    occ_nxt = occ;
    case ({do_push, do_pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  // Ready stays low through reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rdy    <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      occ   <= occ_nxt;
      rdy   <= (occ_nxt < OCC_MAX);
      empty <= (occ_nxt == '0);
      full  <= (occ_nxt == OCC_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/v_upd_sched.sv
// Update scheduler: buffers list-update commands and issues them in order, sharing the state
// read port with queries (query wins). Optional perf counters under V_UPD_SCHED_PERF_EN.
module v_upd_sched
  import v_upd_sched_pkg::*;
#(
  parameter int FIFO_N   = UPD_SCHED_FIFO_N,
  parameter int STARVE_N = UPD_SCHED_STARVE_N
) (
  input  logic          clk,
  input  logic          rst,
  v_upd_sched_if.master bus
);

  localparam int SC_W = $clog2(STARVE_N + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_N);

  upd_cmd_t        head;
  logic            empty, busy, haz, issue;
  logic [SC_W-1:0] starve_cnt, starve_cnt_nxt;
  logic            starve_r;

  v_upd_sched_fifo #(.FIFO_N(FIFO_N)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (bus.i_cmd_vld & bus.o_cmd_rdy),
    .pop    (issue),
    .din    (bus.i_cmd),
    .head   (head),
    .rdy    (bus.o_cmd_rdy),
    .empty  (empty)
  );

  assign busy = ~empty;

  // Head-of-line blocks while any in-flight update still owns the same prod_id.
  assign haz = (bus.i_s1_upd_vld_r && (bus.i_s1_upd_prod_id_r == head.prod_id)) ||
               (bus.i_s2_upd_vld_r && (bus.i_s2_upd_prod_id_r == head.prod_id)) ||
               (bus.i_s3_upd_vld_r && (bus.i_s3_upd_prod_id_r == head.prod_id)) ||
               (bus.i_s4_upd_vld_r && (bus.i_s4_upd_prod_id_r == head.prod_id));

  assign issue = busy & ~bus.i_lut_vld & ~haz;

  assign bus.o_upd_vld     = issue;
  assign bus.o_upd_cmd     = head;
  assign bus.o_state_ren   = bus.i_lut_vld | issue;
  assign bus.o_state_raddr = bus.i_lut_vld ? bus.i_lut_prod_id : head.prod_id;
  assign bus.o_busy        = busy;
  assign bus.o_starve      = starve_r;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!busy || issue)            starve_cnt_nxt = '0;
    else if (starve_cnt != SC_MAX) starve_cnt_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      starve_r   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve_r   <= (starve_cnt_nxt == SC_MAX);
    end
  end

`ifdef V_UPD_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_lut_stall, perf_haz_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue     <= '0;
      perf_lut_stall <= '0;
      perf_haz_stall <= '0;
    end else begin
      if (issue)                         perf_issue     <= perf_issue + 1'b1;
      if (busy && bus.i_lut_vld)         perf_lut_stall <= perf_lut_stall + 1'b1;
      if (busy && !bus.i_lut_vld && haz) perf_haz_stall <= perf_haz_stall + 1'b1;
    end
  end

  assign bus.o_perf_issue_cnt     = perf_issue;
  assign bus.o_perf_lut_stall_cnt = perf_lut_stall;
  assign bus.o_perf_haz_stall_cnt = perf_haz_stall;
`else
  assign bus.o_perf_issue_cnt     = '0;
  assign bus.o_perf_lut_stall_cnt = '0;
  assign bus.o_perf_haz_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_v_upd_sched.sv
// Testbench for v_upd_sched: directed timing checks plus an in-order command scoreboard.
// Perf-counter expectations depend on V_UPD_SCHED_PERF_EN.
module tb_v_upd_sched;
  import v_upd_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_upd_sched_if bus ();

  v_upd_sched #(.FIFO_N(4), .STARVE_N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int       n_cmp = 0;
  int       n_err = 0;
  upd_cmd_t exp_q[$];

  // Downstream S1..S4 model fed by issued updates; hold_* forces an extra S1 occupant.
  logic p_vld [1:4];
  id_t  p_id  [1:4];
  logic hold_vld;
  id_t  hold_id;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 4; i++) begin
        p_vld[i] <= 1'b0;
        p_id[i]  <= '0;
      end
    end else begin
      p_vld[1] <= bus.o_upd_vld;
      p_id[1]  <= bus.o_upd_cmd.prod_id;
      for (int i = 2; i <= 4; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_id[i]  <= p_id[i-1];
      end
    end
  end

  assign bus.i_s1_upd_vld_r     = p_vld[1] | hold_vld;
  assign bus.i_s1_upd_prod_id_r = hold_vld ? hold_id : p_id[1];
  assign bus.i_s2_upd_vld_r     = p_vld[2];
  assign bus.i_s2_upd_prod_id_r = p_id[2];
  assign bus.i_s3_upd_vld_r     = p_vld[3];
  assign bus.i_s3_upd_prod_id_r = p_id[3];
  assign bus.i_s4_upd_vld_r     = p_vld[4];
  assign bus.i_s4_upd_prod_id_r = p_id[4];

  // Scoreboard: accepted commands are queued, every issue must match the oldest one.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_upd_vld) begin
        chk_eq("sb_issue_has_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk_eq("sb_cmd", bus.o_upd_cmd, exp_q.pop_front());
      end
      if (bus.i_cmd_vld && bus.o_cmd_rdy) exp_q.push_back(bus.i_cmd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic v, input id_t id);
    upd_cmd_t c;
    c.op        = upd_op_t'(id[1:0]);
    c.prod_id   = id;
    c.key       = key_t'($urandom());
    c.volume    = vol_t'($urandom());
    bus.i_cmd     = c;
    bus.i_cmd_vld = v;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (bus.o_busy && n < 50) begin
      cyc();
      n++;
    end
    chk_eq(tag, bus.o_busy, 1'b0);
    repeat (5) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cmd_vld     = 1'b0;
    bus.i_cmd         = '0;
    bus.i_lut_vld     = 1'b0;
    bus.i_lut_prod_id = '0;
    hold_vld          = 1'b0;
    hold_id           = '0;

    // Reset state
    repeat (3) @(posedge clk);
    smp();
    chk_eq("rst_rdy",    bus.o_cmd_rdy, 1'b0);
    chk_eq("rst_busy",   bus.o_busy,    1'b0);
    chk_eq("rst_starve", bus.o_starve,  1'b0);
    chk_eq("rst_upd",    bus.o_upd_vld, 1'b0);
    cyc();
    rst = 1'b0;
    cyc(); smp();
    chk_eq("rdy_after_rst", bus.o_cmd_rdy, 1'b1);

    // Single command, free path
    cyc(); drive_cmd(1'b1, 8'd3); smp();
    chk_eq("t1_no_bypass", bus.o_upd_vld, 1'b0);
    cyc(); bus.i_cmd_vld = 1'b0; smp();
    chk_eq("t1_issue", bus.o_upd_vld,     1'b1);
    chk_eq("t1_raddr", bus.o_state_raddr, 8'd3);
    chk_eq("t1_ren",   bus.o_state_ren,   1'b1);
    cyc(); smp();
    chk_eq("t1_busy_after", bus.o_busy,      1'b0);
    chk_eq("t1_ren_idle",   bus.o_state_ren, 1'b0);
    repeat (5) cyc();

    // Query holds the read port
    cyc(); drive_cmd(1'b1, 8'd9); bus.i_lut_vld = 1'b1; bus.i_lut_prod_id = 8'd7; smp();
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.i_cmd_vld = 1'b0; smp();
      chk_eq("t2_lut_raddr",    bus.o_state_raddr, 8'd7);
      chk_eq("t2_lut_ren",      bus.o_state_ren,   1'b1);
      chk_eq("t2_lut_no_issue", bus.o_upd_vld,     1'b0);
    end
    cyc(); bus.i_lut_vld = 1'b0; smp();
    chk_eq("t2_issue", bus.o_upd_vld,     1'b1);
    chk_eq("t2_raddr", bus.o_state_raddr, 8'd9);
    cyc(); smp();
`ifdef V_UPD_SCHED_PERF_EN
    chk_eq("t2_perf_issue",     bus.o_perf_issue_cnt,     32'd2);
    chk_eq("t2_perf_lut_stall", bus.o_perf_lut_stall_cnt, 32'd3);
    chk_eq("t2_perf_haz_stall", bus.o_perf_haz_stall_cnt, 32'd0);
`else
    chk_eq("t2_perf_issue_off",     bus.o_perf_issue_cnt,     32'd0);
    chk_eq("t2_perf_lut_stall_off", bus.o_perf_lut_stall_cnt, 32'd0);
`endif
    repeat (5) cyc();

    // Same prod_id back to back: second waits for the first to leave S4
    cyc(); drive_cmd(1'b1, 8'd5); smp();
    cyc(); drive_cmd(1'b1, 8'd5); smp();
    chk_eq("t3_a_issue", bus.o_upd_vld, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(); bus.i_cmd_vld = 1'b0; smp();
      chk_eq("t3_b_held", bus.o_upd_vld, 1'b0);
      chk_eq("t3_b_busy", bus.o_busy,    1'b1);
    end
    cyc(); smp();
    chk_eq("t3_b_issue", bus.o_upd_vld, 1'b1);
    drain("t3_drain");

    // Fill to full behind a held query
    cyc(); bus.i_lut_vld = 1'b1; bus.i_lut_prod_id = 8'd2;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      drive_cmd(1'b1, id_t'(10 + k)); smp();
      chk_eq("t4_rdy_fill", bus.o_cmd_rdy, 1'b1);
    end
    cyc(); drive_cmd(1'b1, 8'd14); smp();
    chk_eq("t4_full_rdy",      bus.o_cmd_rdy, 1'b0);
    chk_eq("t4_full_no_issue", bus.o_upd_vld, 1'b0);
    cyc(); bus.i_lut_vld = 1'b0; smp();
    chk_eq("t4_pop_issue",  bus.o_upd_vld, 1'b1);
    chk_eq("t4_rdy_on_pop", bus.o_cmd_rdy, 1'b0);
    cyc(); smp();
    chk_eq("t4_rdy_after_pop", bus.o_cmd_rdy, 1'b1);
    cyc(); bus.i_cmd_vld = 1'b0;
    drain("t4_drain");

    // Starvation under a persistent hazard
    cyc(); hold_vld = 1'b1; hold_id = 8'd20; drive_cmd(1'b1, 8'd20); smp();
    for (int k = 1; k <= 8; k++) begin
      cyc(); bus.i_cmd_vld = 1'b0; smp();
      chk_eq("t5_blocked", bus.o_upd_vld, 1'b0);
      chk_eq("t5_not_starved_yet", bus.o_starve, 1'b0);
    end
    cyc(); smp();
    chk_eq("t5_starve", bus.o_starve, 1'b1);
    cyc(); hold_vld = 1'b0; smp();
    chk_eq("t5_issue",       bus.o_upd_vld, 1'b1);
    chk_eq("t5_starve_hold", bus.o_starve,  1'b1);
    cyc(); smp();
    chk_eq("t5_starve_clr", bus.o_starve, 1'b0);
    drain("t5_drain");

    // Reset with commands buffered
    cyc(); bus.i_lut_vld = 1'b1; bus.i_lut_prod_id = 8'd1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      drive_cmd(1'b1, id_t'(30 + k)); smp();
    end
    cyc(); bus.i_cmd_vld = 1'b0; rst = 1'b1; exp_q.delete(); smp();
    chk_eq("t6_rst_busy", bus.o_busy,    1'b0);
    chk_eq("t6_rst_rdy",  bus.o_cmd_rdy, 1'b0);
    chk_eq("t6_rst_upd",  bus.o_upd_vld, 1'b0);
    cyc(); cyc(); rst = 1'b0; bus.i_lut_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); smp();
      chk_eq("t6_idle_upd",  bus.o_upd_vld, 1'b0);
      chk_eq("t6_idle_busy", bus.o_busy,    1'b0);
    end
    cyc(); drive_cmd(1'b1, 8'd40); smp();
    cyc(); bus.i_cmd_vld = 1'b0; smp();
    chk_eq("t6_new_issue", bus.o_upd_vld,     1'b1);
    chk_eq("t6_new_raddr", bus.o_state_raddr, 8'd40);

    repeat (3) cyc();
    chk_eq("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
